// File: rtl/uart_tx_frame.sv
// UART transmitter: DATA_BITS data, optional parity, 1-2 stop bits, LSB first, bits paced by clken.
// Latency: without UART_TX_FIFO_EN an accepted write enters START on the same edge; with it, on the next edge.
// Backpressure: full blocks writes (busy line, or FIFO at FIFO_DEPTH); a write while full is dropped and pulses ovf.

`ifdef UART_TX_FIFO_EN
module uart_tx_frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_rdy,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // full is judged before any same-cycle pop, so a push into a full FIFO is refused
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_rdy && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule
`endif

module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr_en,
    input  logic                 clken,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 full,
    output logic                 ovf
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [BW-1:0]        bitcnt;
    logic                 stopcnt;

    logic                 load_vld;
    logic [DATA_BITS-1:0] load_dat;
    logic                 load_par;

`ifdef UART_TX_FIFO_EN
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        fifo_empty;

    uart_tx_frame_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_50m),
        .rst_n    (rst_n),
        .push_vld (wr_en),
        .push_dat (din),
        .pop_rdy  (load_vld),
        .pop_dat  (load_dat),
        .level    (fifo_level),
        .full     (full),
        .empty    (fifo_empty)
    );

    assign load_vld = (state == IDLE) && !fifo_empty;
    assign tx_busy  = (state != IDLE) || !fifo_empty;
`else
    assign full     = (state != IDLE);
    assign tx_busy  = full;
    assign load_vld = wr_en && (state == IDLE);
    assign load_dat = din;
`endif

    // parity is frozen with the word so later din changes cannot corrupt it
    assign load_par = (PARITY == 1) ? ~(^load_dat) : ^load_dat;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= wr_en && full;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shreg   <= '0;
            par_bit <= 1'b0;
            bitcnt  <= '0;
            stopcnt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_vld) begin
                        shreg   <= load_dat;
                        par_bit <= load_par;
                        bitcnt  <= '0;
                        stopcnt <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (clken) begin
                        tx    <= 1'b0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (clken) begin
                        tx     <= shreg[bitcnt];
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end
                    end
                end
                PAR: begin
                    if (clken) begin
                        tx    <= par_bit;
                        state <= STOP;
                    end
                end
                STOP: begin
                    // the last stop bit is held by the idle line until the next start clken
                    if (clken) begin
                        tx <= 1'b1;
                        if (stopcnt == STOP_LAST) begin
                            state <= IDLE;
                        end else begin
                            stopcnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four parameterisations share clken/reset, each has its own write strobe.
module tb_uart_tx_frame;
    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b1;
    logic       clken   = 1'b0;
    logic [7:0] din8    = '0;
    logic [6:0] din7    = '0;
    logic       wr0 = 1'b0, wre = 1'b0, wro = 1'b0, wr7 = 1'b0;
    logic       tx0, busy0, full0, ovf0;
    logic       txe, busye, fulle, ovfe;
    logic       txo, busyo, fullo, ovfo;
    logic       tx7, busy7, full7, ovf7;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_50m = ~clk_50m;

    uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_def (
        .clk_50m(clk_50m), .rst_n(rst_n), .din(din8), .wr_en(wr0), .clken(clken),
        .tx(tx0), .tx_busy(busy0), .full(full0), .ovf(ovf0));
    uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_even (
        .clk_50m(clk_50m), .rst_n(rst_n), .din(din8), .wr_en(wre), .clken(clken),
        .tx(txe), .tx_busy(busye), .full(fulle), .ovf(ovfe));
    uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_odd (
        .clk_50m(clk_50m), .rst_n(rst_n), .din(din8), .wr_en(wro), .clken(clken),
        .tx(txo), .tx_busy(busyo), .full(fullo), .ovf(ovfo));
    uart_tx_frame #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7b2 (
        .clk_50m(clk_50m), .rst_n(rst_n), .din(din7), .wr_en(wr7), .clken(clken),
        .tx(tx7), .tx_busy(busy7), .full(full7), .ovf(ovf7));

    task automatic tick;
        @(posedge clk_50m);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse;
        clken = 1'b1;
        tick();
        clken = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (tx0 !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", tx0); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy0); end
        vectors++; if (full0 !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full0); end
        vectors++; if (ovf0 !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", ovf0); end
        vectors++; if ({txe, txo, tx7} !== 3'b111) begin
            miscompares++; $display("FAIL reset_tx_all got %b want 111", {txe, txo, tx7}); end
        vectors++; if ({busye, fulle, ovfe, busyo, fullo, ovfo, busy7, full7, ovf7} !== 9'b0) begin
            miscompares++; $display("FAIL reset_flags_all got %b want 000000000",
                {busye, fulle, ovfe, busyo, fullo, ovfo, busy7, full7, ovf7}); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        logic want [10];
        want = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        din8 = 8'h55; wr0 = 1'b1; tick(); wr0 = 1'b0; din8 = 8'h00;
        vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL basic_busy_load got %b want 1", busy0); end
        idle(1);
        for (int i = 0; i < 10; i++) begin
            pulse();
            vectors++; if (tx0 !== want[i]) begin
                miscompares++; $display("FAIL basic_bit%0d got %b want %b", i, tx0, want[i]); end
            vectors++; if (busy0 !== (i != 9)) begin
                miscompares++; $display("FAIL basic_busy%0d got %b want %b", i, busy0, (i != 9)); end
            idle(15);
            vectors++; if (tx0 !== want[i]) begin
                miscompares++; $display("FAIL basic_hold%0d got %b want %b", i, tx0, want[i]); end
        end
        pulse();
        vectors++; if ({tx0, busy0} !== 2'b10) begin
            miscompares++; $display("FAIL idle_clken got tx,busy=%b want 10", {tx0, busy0}); end
        idle(2);
    endtask

    task automatic test_parity;
        logic want_e [11];
        logic want_o [11];
        logic want_7 [11];
        want_e = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        want_o = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        want_7 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        din8 = 8'h55; wre = 1'b1; wro = 1'b1; tick(); wre = 1'b0; wro = 1'b0; din8 = 8'hFF;
        idle(1);
        for (int i = 0; i < 11; i++) begin
            pulse();
            vectors++; if (txe !== want_e[i]) begin
                miscompares++; $display("FAIL even55_bit%0d got %b want %b", i, txe, want_e[i]); end
            vectors++; if (txo !== want_o[i]) begin
                miscompares++; $display("FAIL odd55_bit%0d got %b want %b", i, txo, want_o[i]); end
            idle(3);
        end
        vectors++; if ({busye, busyo} !== 2'b00) begin
            miscompares++; $display("FAIL parity_busy_end got %b want 00", {busye, busyo}); end
        din8 = 8'h07; wre = 1'b1; tick(); wre = 1'b0; din8 = 8'h00;
        idle(1);
        for (int i = 0; i < 11; i++) begin
            pulse();
            vectors++; if (txe !== want_7[i]) begin
                miscompares++; $display("FAIL even07_bit%0d got %b want %b", i, txe, want_7[i]); end
            idle(3);
        end
    endtask

    task automatic test_7bit_2stop;
        logic want [10];
        want = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        din7 = 7'h41; wr7 = 1'b1; tick(); wr7 = 1'b0; din7 = 7'h00;
        idle(1);
        for (int i = 0; i < 10; i++) begin
            pulse();
            vectors++; if (tx7 !== want[i]) begin
                miscompares++; $display("FAIL b7s2_bit%0d got %b want %b", i, tx7, want[i]); end
            vectors++; if (busy7 !== (i != 9)) begin
                miscompares++; $display("FAIL b7s2_busy%0d got %b want %b", i, busy7, (i != 9)); end
            idle(3);
        end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo;
        logic [7:0] w;
        logic       bit_want;
        wr0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            din8 = 8'hA0 + 8'(k);
            tick();
            if (k == 0) begin
                vectors++; if ({busy0, full0} !== 2'b10) begin
                    miscompares++; $display("FAIL fifo_first got busy,full=%b want 10", {busy0, full0}); end
            end
            if (k == 4) begin
                vectors++; if ({full0, ovf0} !== 2'b10) begin
                    miscompares++; $display("FAIL fifo_fill got full,ovf=%b want 10", {full0, ovf0}); end
            end
            if (k == 5) begin
                vectors++; if (ovf0 !== 1'b1) begin miscompares++; $display("FAIL fifo_ovf got %b want 1", ovf0); end
            end
        end
        wr0 = 1'b0;
        tick();
        vectors++; if ({ovf0, full0} !== 2'b01) begin
            miscompares++; $display("FAIL fifo_ovf_end got ovf,full=%b want 01", {ovf0, full0}); end
        for (int f = 0; f < 5; f++) begin
            w = 8'hA0 + 8'(f);
            for (int j = 0; j < 10; j++) begin
                bit_want = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : w[j-1];
                pulse();
                vectors++; if (tx0 !== bit_want) begin
                    miscompares++; $display("FAIL fifo_f%0d_bit%0d got %b want %b", f, j, tx0, bit_want); end
                idle(3);
            end
        end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL fifo_drain_busy got %b want 0", busy0); end
    endtask
`else
    task automatic test_busy_overflow;
        logic want [10];
        want = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        din8 = 8'h3C; wr0 = 1'b1; tick(); wr0 = 1'b0;
        vectors++; if ({full0, ovf0} !== 2'b10) begin
            miscompares++; $display("FAIL ovf_accept got full,ovf=%b want 10", {full0, ovf0}); end
        din8 = 8'hFF; wr0 = 1'b1; tick(); wr0 = 1'b0;
        vectors++; if (ovf0 !== 1'b1) begin miscompares++; $display("FAIL ovf_start got %b want 1", ovf0); end
        tick();
        vectors++; if (ovf0 !== 1'b0) begin miscompares++; $display("FAIL ovf_one_cycle got %b want 0", ovf0); end
        for (int i = 0; i < 10; i++) begin
            pulse();
            vectors++; if (tx0 !== want[i]) begin
                miscompares++; $display("FAIL ovf_frame_bit%0d got %b want %b", i, tx0, want[i]); end
            if (i == 4) begin
                wr0 = 1'b1; tick(); wr0 = 1'b0;
                vectors++; if (ovf0 !== 1'b1) begin miscompares++; $display("FAIL ovf_mid got %b want 1", ovf0); end
            end
            idle(3);
        end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL ovf_busy_end got %b want 0", busy0); end
    endtask
`endif

    task automatic test_reset_midframe;
        logic want [10];
        want = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        din8 = 8'hA5; wr0 = 1'b1; tick(); wr0 = 1'b0;
        idle(1);
        for (int i = 0; i < 3; i++) begin
            pulse();
            if (i < 2) idle(3);
        end
        vectors++; if (tx0 !== 1'b0) begin miscompares++; $display("FAIL mid_pre_reset got %b want 0", tx0); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({tx0, busy0, full0, ovf0} !== 4'b1000) begin
            miscompares++; $display("FAIL mid_reset got tx,busy,full,ovf=%b want 1000", {tx0, busy0, full0, ovf0}); end
        tick();
        rst_n = 1'b1;
        tick();
        din8 = 8'h55; wr0 = 1'b1; tick(); wr0 = 1'b0;
        idle(1);
        for (int i = 0; i < 10; i++) begin
            pulse();
            vectors++; if (tx0 !== want[i]) begin
                miscompares++; $display("FAIL post_reset_bit%0d got %b want %b", i, tx0, want[i]); end
            idle(3);
        end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy got %b want 0", busy0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_7bit_2stop();
`ifdef UART_TX_FIFO_EN
        test_fifo();
`else
        test_busy_overflow();
`endif
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
